// File: rtl/ecc_res_pkg.sv
// rtl/ecc_res_pkg.sv - shared error-code type and default sizes for the ECC result collector
package ecc_res_pkg;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_SINGLE = 2'd1,
    ERR_DOUBLE = 2'd2,
    ERR_RSVD   = 2'd3
  } err_code_t;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_DEPTH      = 8;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/ecc_res_fifo.sv
// rtl/ecc_res_fifo.sv - generic synchronous FIFO with registered occupancy, no fall-through
module ecc_res_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_wr, do_rd;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;

  // A write into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_rd = rd_en_i & ~empty_o;
  assign do_wr = wr_en_i & (~full_o | do_rd);

  // Head is forced to zero when empty so reset and drained states read back as 0.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/ecc_result_collector.sv
// rtl/ecc_result_collector.sv - queues ECC decode results and keeps saturating error statistics
module ecc_result_collector
  import ecc_res_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   data_out,
  input  logic                    operation_done,
  input  logic [1:0]              num_of_errors,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic [1:0]              m_err,
  output logic                    m_valid,
  input  logic                    m_ready,
  input  logic                    clr_stats,
  output logic [CNT_WIDTH-1:0]    cnt_ops,
  output logic [CNT_WIDTH-1:0]    cnt_single,
  output logic [CNT_WIDTH-1:0]    cnt_double,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  level
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                  fifo_full, fifo_empty;
  logic                  pop, drop;
  err_code_t             code;
  logic [CNT_WIDTH-1:0]  cnt_ops_q, cnt_ops_d;
  logic [CNT_WIDTH-1:0]  cnt_single_q, cnt_single_d;
  logic [CNT_WIDTH-1:0]  cnt_double_q, cnt_double_d;
  logic                  overflow_q, overflow_d;

  ecc_res_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (operation_done),
    .wr_data_i ({data_out, num_of_errors}),
    .rd_en_i   (m_ready),
    .rd_data_o ({m_data, m_err}),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level)
  );

  assign m_valid = ~fifo_empty;
  assign pop     = m_valid & m_ready;
  assign drop    = operation_done & fifo_full & ~pop;
  assign code    = err_code_t'(num_of_errors);

  // Clear has priority over any same-cycle result; counters stick at all-ones.
  always_comb begin
    cnt_ops_d    = cnt_ops_q;
    cnt_single_d = cnt_single_q;
    cnt_double_d = cnt_double_q;
    overflow_d   = overflow_q;
    if (clr_stats) begin
      cnt_ops_d    = '0;
      cnt_single_d = '0;
      cnt_double_d = '0;
      overflow_d   = 1'b0;
    end else begin
      if (drop) overflow_d = 1'b1;
      if (operation_done) begin
        if (cnt_ops_q != CNT_MAX) cnt_ops_d = cnt_ops_q + CNT_WIDTH'(1);
        if (code == ERR_SINGLE && cnt_single_q != CNT_MAX)
          cnt_single_d = cnt_single_q + CNT_WIDTH'(1);
        if (code == ERR_DOUBLE && cnt_double_q != CNT_MAX)
          cnt_double_d = cnt_double_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_ops_q    <= '0;
      cnt_single_q <= '0;
      cnt_double_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      cnt_ops_q    <= cnt_ops_d;
      cnt_single_q <= cnt_single_d;
      cnt_double_q <= cnt_double_d;
      overflow_q   <= overflow_d;
    end
  end

  assign cnt_ops    = cnt_ops_q;
  assign cnt_single = cnt_single_q;
  assign cnt_double = cnt_double_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ecc_result_collector.sv
// tb/tb_ecc_result_collector.sv - table-driven bench for the ECC result collector
module tb_ecc_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_out;
  logic        operation_done;
  logic [1:0]  num_of_errors;
  logic [31:0] m_data;
  logic [1:0]  m_err;
  logic        m_valid;
  logic        m_ready;
  logic        clr_stats;
  logic [15:0] cnt_ops, cnt_single, cnt_double;
  logic        overflow;
  logic [3:0]  level;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ecc_result_collector #(.DATA_WIDTH(32), .DEPTH(8), .CNT_WIDTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_out       (data_out),
    .operation_done (operation_done),
    .num_of_errors  (num_of_errors),
    .m_data         (m_data),
    .m_err          (m_err),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .clr_stats      (clr_stats),
    .cnt_ops        (cnt_ops),
    .cnt_single     (cnt_single),
    .cnt_double     (cnt_double),
    .overflow       (overflow),
    .level          (level)
  );

  typedef struct {
    logic        op;
    logic [31:0] data;
    logic [1:0]  code;
    logic        rdy;
    logic        clr;
    logic        e_valid;
    logic [31:0] e_data;
    logic [1:0]  e_err;
    logic [3:0]  e_level;
    logic [15:0] e_ops;
    logic [15:0] e_single;
    logic [15:0] e_double;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic op, input logic [31:0] data, input logic [1:0] code,
                              input logic rdy, input logic clr, input logic ev,
                              input logic [31:0] ed, input logic [1:0] ee, input int el,
                              input int eo, input int es, input int edb, input logic eovf);
    vec_t v;
    v.op = op; v.data = data; v.code = code; v.rdy = rdy; v.clr = clr;
    v.e_valid = ev; v.e_data = ed; v.e_err = ee; v.e_level = 4'(el);
    v.e_ops = 16'(eo); v.e_single = 16'(es); v.e_double = 16'(edb); v.e_ovf = eovf;
    return v;
  endfunction

  task automatic check_outputs(input string tag, input logic ev, input logic [31:0] ed,
                               input logic [1:0] ee, input logic [3:0] el, input logic [15:0] eo,
                               input logic [15:0] es, input logic [15:0] edb, input logic eovf);
    chk({tag, ".m_valid"}, 32'(m_valid), 32'(ev));
    chk({tag, ".m_data"}, m_data, ed);
    chk({tag, ".m_err"}, 32'(m_err), 32'(ee));
    chk({tag, ".level"}, 32'(level), 32'(el));
    chk({tag, ".cnt_ops"}, 32'(cnt_ops), 32'(eo));
    chk({tag, ".cnt_single"}, 32'(cnt_single), 32'(es));
    chk({tag, ".cnt_double"}, 32'(cnt_double), 32'(edb));
    chk({tag, ".overflow"}, 32'(overflow), 32'(eovf));
  endtask

  initial begin
    // Three-result ordering and one-cycle visibility
    vecs.push_back(mk(1, 32'hA5A5A5A5, 0, 1, 0, 1, 32'hA5A5A5A5, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h12345678, 1, 1, 0, 1, 32'h12345678, 1, 1, 2, 1, 0, 0));
    vecs.push_back(mk(1, 32'hDEADBEEF, 2, 1, 0, 1, 32'hDEADBEEF, 2, 1, 3, 1, 1, 0));
    vecs.push_back(mk(0, 32'h0,        0, 1, 0, 0, 32'h0,        0, 0, 3, 1, 1, 0));
    // Nine pushes with consumer stalled: ninth dropped, head held
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk(1, 32'h100 + i, 0, 0, 0, 1, 32'h100, 0, (i < 8) ? i + 1 : 8,
                        4 + i, 1, 1, (i == 8)));
    for (int j = 1; j <= 8; j++)
      vecs.push_back(mk(0, 0, 0, 1, 0, (j < 8), (j < 8) ? 32'h100 + j : 32'h0, 0, 8 - j,
                        12, 1, 1, 1));
    // Clear, refill, then push+pop while full
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 32'h200 + i, 2'(i % 4), 0, 0, 1, 32'h200, 0, i + 1,
                        i + 1, (i + 3) / 4, (i + 2) / 4, 0));
    vecs.push_back(mk(1, 32'h2FF, 1, 1, 0, 1, 32'h201, 1, 8, 9, 3, 2, 0));
    for (int j = 1; j <= 8; j++) begin
      logic [31:0] hd;
      logic [1:0]  he;
      hd = (j < 7) ? 32'h201 + j : (j == 7) ? 32'h2FF : 32'h0;
      he = (j < 7) ? 2'((1 + j) % 4) : (j == 7) ? 2'd1 : 2'd0;
      vecs.push_back(mk(0, 0, 0, 1, 0, (j < 8), hd, he, 8 - j, 9, 3, 2, 0));
    end

    rst = 1'b1;
    data_out = '0; operation_done = 1'b0; num_of_errors = '0; m_ready = 1'b0; clr_stats = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 0, 32'h0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      operation_done = vecs[i].op;
      data_out       = vecs[i].data;
      num_of_errors  = vecs[i].code;
      m_ready        = vecs[i].rdy;
      clr_stats      = vecs[i].clr;
      @(posedge clk);
      #1;
      check_outputs($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_data, vecs[i].e_err,
                    vecs[i].e_level, vecs[i].e_ops, vecs[i].e_single, vecs[i].e_double,
                    vecs[i].e_ovf);
    end

    // Saturation: clear then stream code-1 results with the consumer draining each cycle
    @(negedge clk);
    operation_done = 1'b0; clr_stats = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0; operation_done = 1'b1; num_of_errors = 2'd1; data_out = 32'hCAFE0001;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat.pre_single", 32'(cnt_single), 32'hFFFE);
    chk("sat.pre_ops", 32'(cnt_ops), 32'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    chk("sat.single", 32'(cnt_single), 32'hFFFF);
    chk("sat.ops", 32'(cnt_ops), 32'hFFFF);
    chk("sat.double", 32'(cnt_double), 32'h0);
    @(negedge clk);
    clr_stats = 1'b1; num_of_errors = 2'd2; data_out = 32'hCAFE0002;
    @(posedge clk);
    #1;
    check_outputs("clr_vs_event", 1, 32'hCAFE0002, 2, 1, 0, 0, 0, 0);

    // Asynchronous reset with five entries queued
    @(negedge clk);
    clr_stats = 1'b0; operation_done = 1'b0;
    @(negedge clk);
    operation_done = 1'b1; m_ready = 1'b0; num_of_errors = 2'd1; data_out = 32'h55;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst.level", 32'(level), 32'd5);
    @(negedge clk);
    operation_done = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_outputs("async_rst", 0, 32'h0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    operation_done = 1'b1; data_out = 32'h00000001; num_of_errors = 2'd3;
    @(posedge clk);
    #1;
    check_outputs("post_rst", 1, 32'h00000001, 3, 1, 1, 0, 0, 0);
    @(negedge clk);
    operation_done = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_result_collector.md
ECC_RESULT_COLLECTOR -- requirements
Module: ecc_result_collector

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of decoded data word from ECC_ENC_DEC data_out.
REQ-002 Parameter: DEPTH, 8, result FIFO entries; power of two, >= 2.
REQ-003 Parameter: CNT_WIDTH, 16, width of each statistics counter.
REQ-004 Port: clk  in  1  single clock; all logic on its rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-high.
REQ-006 Port: data_out  in  DATA_WIDTH  result word from ECC_ENC_DEC.
REQ-007 Port: operation_done  in  1  one-cycle pulse; data_out/num_of_errors valid in that cycle.
REQ-008 Port: num_of_errors  in  2  error code: 0 none, 1 single corrected, 2 double detected, 3 reserved.
REQ-009 Port: m_data  out  DATA_WIDTH  FIFO head data.
REQ-010 Port: m_err  out  2  FIFO head error code.
REQ-011 Port: m_valid  out  1  head entry valid.
REQ-012 Port: m_ready  in  1  consumer accepts head.
REQ-013 Port: clr_stats  in  1  synchronous clear of counters and overflow flag.
REQ-014 Port: cnt_ops, cnt_single, cnt_double  out  CNT_WIDTH each  operation, single-error, double-error counts.
REQ-015 Port: overflow  out  1  sticky: a result was dropped because FIFO full.
REQ-016 Port: level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Push: operation_done=1 and FIFO not full (or full with pop in same cycle) writes {data_out, num_of_errors} at write pointer.
REQ-018 Pop: m_valid=1 and m_ready=1 in a cycle removes head; next entry presented the following cycle.
REQ-019 Latency: entry pushed into empty FIFO at edge N drives m_valid=1 from after edge N (visible cycle N+1); no same-cycle fall-through.
REQ-020 m_data/m_err hold stable while m_valid=1 and m_ready=0.
REQ-021 Pointers wrap modulo DEPTH; level = writes - pops, range 0..DEPTH.
REQ-022 Simultaneous push and pop: level unchanged; legal when full and when level=1.
REQ-023 Push while full without pop: entry dropped, FIFO unchanged, overflow set to 1 next cycle.
REQ-024 Every operation_done pulse, including dropped ones, increments cnt_ops; code 1 increments cnt_single; code 2 increments cnt_double; code 3 counts only in cnt_ops.
REQ-025 Counters saturate at 2^CNT_WIDTH-1; no wrap.
REQ-026 clr_stats=1 zeroes all counters and overflow next cycle; clear wins over a same-cycle event (event not counted); FIFO contents untouched.
REQ-027 operation_done held high for k cycles is treated as k separate results.

Reset
REQ-028 rst=1 asynchronously forces: pointers 0, level 0, m_valid 0, m_data 0, m_err 0, all counters 0, overflow 0.
REQ-029 Reset mid-operation discards all FIFO entries; first operation_done after deassertion is processed normally.

Structure
REQ-030 Package ecc_res_pkg holds err_code_t enum (ERR_NONE=0, ERR_SINGLE=1, ERR_DOUBLE=2, ERR_RSVD=3) and default parameter constants.
REQ-031 One sub-module, ecc_res_fifo (generic synchronous FIFO, width DATA_WIDTH+2, DEPTH entries, full/empty/level); counters and overflow logic in top.

Verification
REQ-032 After reset, 3 pulses (0xA5A5A5A5/code0, 0x12345678/code1, 0xDEADBEEF/code2), m_ready=1 -> m_data in same order, each m_valid one cycle after push; cnt_ops=3, cnt_single=1, cnt_double=1.
REQ-033 m_ready=0, 9 pulses with DEPTH=8 -> level=8, overflow=1, cnt_ops=9; then draining yields first 8 words in order, level 0, m_valid 0.
REQ-034 FIFO full, push and pop same cycle -> level stays 8, overflow stays 0, new word appears last on drain.
REQ-035 Force cnt_single to 0xFFFE, 3 code-1 pulses -> cnt_single=0xFFFF; clr_stats coincident with code-2 pulse -> all counters 0, cnt_double 0.
REQ-036 rst asserted mid-stream with level=5 -> m_valid 0, level 0, counters 0 immediately (asynchronous); next pulse 0x00000001/code3 -> cnt_ops=1, cnt_single=0, cnt_double=0.
